pipe_adder: RTL



---
 rtl/adder_pkg.sv | 15 +
 rtl/adder_seg.sv | 29 ++
 rtl/pipe_adder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared constants and parameter helpers for the pipelined adder family.
package adder_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultSeg   = 2;

    function automatic int unsigned num_stages(int unsigned width, int unsigned seg);
        return (seg == 0) ? 1 : width / seg;
    endfunction

    function automatic bit params_ok(int unsigned width, int unsigned seg);
        return (seg != 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple slice; also exposes the carry into its MSB so the
// top stage can derive signed overflow.
module adder_seg #(
    parameter int unsigned SEG = 2
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [SEG:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = c[SEG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: one SEG-bit slice per stage, carry registered between
// stages, operands skewed in and sum segments deskewed so results emerge aligned.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned SEG   = DefaultSeg
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned STAGES = num_stages(WIDTH, SEG);

    if (!params_ok(WIDTH, SEG)) begin : g_param_check
        $error("pipe_adder: WIDTH must be a non-zero multiple of SEG");
    end

    logic             stall;
    logic             accept;
    logic [WIDTH-1:0] bx;
    logic             c0;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             out_valid_q;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    // Subtraction as A + ~B + ~borrow.
    assign bx = Sub ? ~B : B;
    assign c0 = Sub ^ Cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned Lo = k * SEG;

        // Operand bits still to be consumed, and sum bits finished so far.
        logic [WIDTH-1:Lo]    a_cur;
        logic [WIDTH-1:Lo]    bx_cur;
        logic                 c_cur;
        logic                 v_cur;
        logic [Lo+SEG-1:0]    done;
        logic [SEG-1:0]       seg_s;
        logic                 seg_co;
        logic                 seg_cm;

        if (k == 0) begin : g_in
            assign a_cur  = A;
            assign bx_cur = bx;
            assign c_cur  = c0;
            assign v_cur  = accept;
            assign done   = seg_s;
        end else begin : g_in
            assign a_cur  = g_stage[k-1].g_reg.a_q;
            assign bx_cur = g_stage[k-1].g_reg.bx_q;
            assign c_cur  = g_stage[k-1].g_reg.c_q;
            assign v_cur  = g_stage[k-1].g_reg.v_q;
            assign done   = {seg_s, g_stage[k-1].g_reg.part_q};
        end

        adder_seg #(
            .SEG(SEG)
        ) u_seg (
            .a    (a_cur[Lo+:SEG]),
            .b    (bx_cur[Lo+:SEG]),
            .ci   (c_cur),
            .s    (seg_s),
            .co   (seg_co),
            .c_msb(seg_cm)
        );

        if (k < STAGES - 1) begin : g_reg
            logic [WIDTH-1:Lo+SEG] a_q;
            logic [WIDTH-1:Lo+SEG] bx_q;
            logic [Lo+SEG-1:0]     part_q;
            logic                  c_q;
            logic                  v_q;
            logic                  unused_cm;

            assign unused_cm = seg_cm;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (!stall) begin
                    v_q    <= v_cur;
                    a_q    <= a_cur[WIDTH-1:Lo+SEG];
                    bx_q   <= bx_cur[WIDTH-1:Lo+SEG];
                    part_q <= done;
                    c_q    <= seg_co;
                end
            end
        end else begin : g_out
            // Signed overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    cout_q      <= 1'b0;
                    ovf_q       <= 1'b0;
                end else if (!stall) begin
                    out_valid_q <= v_cur;
                    sum_q       <= done;
                    cout_q      <= seg_co;
                    ovf_q       <= seg_co ^ seg_cm;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule
